// File: rtl/laundry_scheduler.sv
// Round-robin scheduler sharing one washer and one laundry carrier among four floors.
// Latches floor requests, dispatches the carrier, runs the wash and reports completion.
module laundry_scheduler #(
  parameter int LOAD_CYCLES  = 4,
  parameter int MOVE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] req_laundry,
  input  logic [2:0] at_floor,
  input  logic       wash_done,
  output logic       move_req,
  output logic [2:0] target_floor,
  output logic       wash_start,
  output logic [3:0] grant,
  output logic       serve_done,
  output logic [3:0] pending,
  output logic       busy,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_PICKUP,
    S_LOAD,
    S_HOME,
    S_WASH,
    S_FAULT
  } state_t;

  localparam logic [15:0] L_MOVE_TIMEOUT = 16'(MOVE_TIMEOUT);
  localparam logic [7:0]  L_LOAD_LAST    = 8'(LOAD_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_pending;
  logic [3:0]  r_grant;
  logic [1:0]  r_idx;
  logic [1:0]  r_rr;
  logic        r_move_req;
  logic [2:0]  r_target;
  logic        r_wash_start;
  logic        r_serve_done;
  logic        r_fault;
  logic [15:0] r_move_cnt;
  logic [7:0]  r_load_cnt;

  state_t      w_state_nx;
  logic [3:0]  w_grant_nx;
  logic [1:0]  w_idx_nx;
  logic [1:0]  w_rr_nx;
  logic        w_move_req_nx;
  logic [2:0]  w_target_nx;
  logic        w_wash_start_nx;
  logic        w_serve_done_nx;
  logic        w_fault_nx;
  logic [15:0] w_move_cnt_nx;
  logic [7:0]  w_load_cnt_nx;
  logic [3:0]  w_clr;

  logic        w_found;
  logic [1:0]  w_sel_idx;
  logic [3:0]  w_sel_onehot;
  logic [15:0] w_move_inc;
  logic        w_move_expired;

  // Round-robin search: first pending bit at or above r_rr, wrapping 3 -> 0.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_found   = 1'b0;
    w_sel_idx = r_rr;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && r_pending[r_rr + 2'(k)]) begin
        w_found   = 1'b1;
        w_sel_idx = r_rr + 2'(k);
      end
    end
  end

  assign w_sel_onehot   = 4'b0001 << w_sel_idx;
  assign w_move_inc     = (r_move_cnt >= L_MOVE_TIMEOUT) ? r_move_cnt : r_move_cnt + 16'd1;
  assign w_move_expired = (w_move_inc >= L_MOVE_TIMEOUT);

  always_comb begin
    w_state_nx      = r_state;
    w_grant_nx      = r_grant;
    w_idx_nx        = r_idx;
    w_rr_nx         = r_rr;
    w_move_req_nx   = r_move_req;
    w_target_nx     = r_target;
    w_wash_start_nx = 1'b0;
    w_serve_done_nx = 1'b0;
    w_fault_nx      = r_fault;
    w_move_cnt_nx   = r_move_cnt;
    w_load_cnt_nx   = r_load_cnt;
    w_clr           = 4'b0000;

    unique case (r_state)
      S_IDLE: begin
        if (start && (r_pending != 4'b0000)) w_state_nx = S_ARB;
      end
      S_ARB: begin
        if (w_found) begin
          w_clr         = w_sel_onehot;
          w_grant_nx    = w_sel_onehot;
          w_idx_nx      = w_sel_idx;
          w_move_req_nx = 1'b1;
          w_target_nx   = {1'b0, w_sel_idx} + 3'd1;
          w_state_nx    = S_PICKUP;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_PICKUP: begin
        if (at_floor == r_target) begin
          w_move_req_nx = 1'b0;
          w_state_nx    = S_LOAD;
        end else if (w_move_expired) begin
          w_state_nx = S_FAULT;
        end else begin
          w_move_cnt_nx = w_move_inc;
        end
      end
      S_LOAD: begin
        if (r_load_cnt == L_LOAD_LAST) begin
          w_target_nx   = 3'd0;
          w_move_req_nx = 1'b1;
          w_state_nx    = S_HOME;
        end else begin
          w_load_cnt_nx = r_load_cnt + 8'd1;
        end
      end
      S_HOME: begin
        if (at_floor == 3'd0) begin
          w_move_req_nx   = 1'b0;
          w_wash_start_nx = 1'b1;
          w_state_nx      = S_WASH;
        end else if (w_move_expired) begin
          w_state_nx = S_FAULT;
        end else begin
          w_move_cnt_nx = w_move_inc;
        end
      end
      S_WASH: begin
        if (wash_done) begin
          w_serve_done_nx = 1'b1;
          w_rr_nx         = r_idx + 2'd1;
          w_grant_nx      = 4'b0000;
          w_state_nx      = S_IDLE;
        end
      end
      S_FAULT: begin
        w_state_nx = S_FAULT;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    if (w_state_nx == S_FAULT) begin
      w_move_req_nx   = 1'b0;
      w_wash_start_nx = 1'b0;
      w_grant_nx      = 4'b0000;
      w_fault_nx      = 1'b1;
    end

    // Both counters restart whenever the state changes.
    if (w_state_nx != r_state) begin
      w_move_cnt_nx = 16'd0;
      w_load_cnt_nx = 8'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pending    <= 4'b0000;
      r_grant      <= 4'b0000;
      r_idx        <= 2'd0;
      r_rr         <= 2'd0;
      r_move_req   <= 1'b0;
      r_target     <= 3'd0;
      r_wash_start <= 1'b0;
      r_serve_done <= 1'b0;
      r_fault      <= 1'b0;
      r_move_cnt   <= 16'd0;
      r_load_cnt   <= 8'd0;
    end else begin
      r_state      <= w_state_nx;
      r_pending    <= (r_pending & ~w_clr) | req_laundry;
      r_grant      <= w_grant_nx;
      r_idx        <= w_idx_nx;
      r_rr         <= w_rr_nx;
      r_move_req   <= w_move_req_nx;
      r_target     <= w_target_nx;
      r_wash_start <= w_wash_start_nx;
      r_serve_done <= w_serve_done_nx;
      r_fault      <= w_fault_nx;
      r_move_cnt   <= w_move_cnt_nx;
      r_load_cnt   <= w_load_cnt_nx;
    end
  end

  assign move_req     = r_move_req;
  assign target_floor = r_target;
  assign wash_start   = r_wash_start;
  assign grant        = r_grant;
  assign serve_done   = r_serve_done;
  assign pending      = r_pending;
  assign busy         = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign fault        = r_fault;

endmodule

// File: tb/tb_laundry_scheduler.sv
// Self-checking bench for laundry_scheduler: carrier and washer models plus
// a round-robin job table and directed sequences for reset, timing and fault cases.
module tb_laundry_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] req_laundry;
  logic [2:0] at_floor = 3'd0;
  logic       wash_done = 1'b0;
  logic       move_req;
  logic [2:0] target_floor;
  logic       wash_start;
  logic [3:0] grant;
  logic       serve_done;
  logic [3:0] pending;
  logic       busy;
  logic       fault;

  int checks = 0;
  int errors = 0;

  logic carrier_en = 1'b1;
  int   mv_cnt     = 0;
  int   wash_cnt   = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
    logic [2:0] exp_target;
  } rr_vec_t;

  rr_vec_t vecs[7];

  laundry_scheduler #(.LOAD_CYCLES(4), .MOVE_TIMEOUT(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .req_laundry  (req_laundry),
    .at_floor     (at_floor),
    .wash_done    (wash_done),
    .move_req     (move_req),
    .target_floor (target_floor),
    .wash_start   (wash_start),
    .grant        (grant),
    .serve_done   (serve_done),
    .pending      (pending),
    .busy         (busy),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  // Carrier: reaches the commanded floor three cycles after the move is seen; parked at 0 when disabled.
  always @(negedge clk) begin
    if (!carrier_en) begin
      at_floor = 3'd0;
      mv_cnt   = 0;
    end else if (move_req && (at_floor != target_floor)) begin
      mv_cnt = mv_cnt + 1;
      if (mv_cnt == 3) begin
        at_floor = target_floor;
        mv_cnt   = 0;
      end
    end else begin
      mv_cnt = 0;
    end
  end

  // Washer: one-cycle wash_done pulse a few cycles after wash_start.
  always @(negedge clk) begin
    wash_done = 1'b0;
    if (wash_start) begin
      wash_cnt = 4;
    end else if (wash_cnt != 0) begin
      wash_cnt = wash_cnt - 1;
      if (wash_cnt == 0) wash_done = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_move_req"},   32'(move_req),     32'd0);
    check({tag, "_target"},     32'(target_floor), 32'd0);
    check({tag, "_wash_start"}, 32'(wash_start),   32'd0);
    check({tag, "_grant"},      32'(grant),        32'd0);
    check({tag, "_serve_done"}, 32'(serve_done),   32'd0);
    check({tag, "_pending"},    32'(pending),      32'd0);
    check({tag, "_busy"},       32'(busy),         32'd0);
    check({tag, "_fault"},      32'(fault),        32'd0);
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    start       = 1'b0;
    req_laundry = 4'b0000;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_req(input logic [3:0] r);
    req_laundry = r;
    @(negedge clk);
    req_laundry = 4'b0000;
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while ((grant == 4'b0000) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    check({name, "_grant_seen"}, 32'(grant != 4'b0000), 32'd1);
  endtask

  task automatic wait_serve(input string name);
    int n = 0;
    while (!serve_done && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    check({name, "_serve_seen"}, 32'(serve_done), 32'd1);
  endtask

  initial begin
    int n;
    int load_len;
    int pulse_len;
    logic saw_busy;

    // Floor 1 and 4 alternate; after the switch to 4'b1000 the stale floor-1
    // latch is served once more before floor 4 repeats.
    vecs[0] = '{4'b1001, 4'b0001, 3'd1};
    vecs[1] = '{4'b1001, 4'b1000, 3'd4};
    vecs[2] = '{4'b1001, 4'b0001, 3'd1};
    vecs[3] = '{4'b1001, 4'b1000, 3'd4};
    vecs[4] = '{4'b1000, 4'b0001, 3'd1};
    vecs[5] = '{4'b1000, 4'b1000, 3'd4};
    vecs[6] = '{4'b1000, 4'b1000, 3'd4};

    // Reset holds everything at zero even with all requests high.
    reset       = 1'b0;
    start       = 1'b0;
    req_laundry = 4'b1111;
    repeat (2) @(negedge clk);
    check_all_zero("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_rel_pending",  32'(pending),  32'hf);
    check("rst_rel_move_req", 32'(move_req), 32'd0);
    check("rst_rel_busy",     32'(busy),     32'd0);

    // Single request: latency, LOAD length, return home, wash pulses.
    do_reset();
    start       = 1'b1;
    req_laundry = 4'b1000;
    @(negedge clk);
    req_laundry = 4'b0000;
    check("single_pending_e0", 32'(pending), 32'h8);
    check("single_idle_e0",    32'(busy),    32'd0);
    @(negedge clk);
    check("single_arb_busy",   32'(busy),     32'd1);
    check("single_arb_move",   32'(move_req), 32'd0);
    @(negedge clk);
    check("single_move_req",   32'(move_req),     32'd1);
    check("single_target",     32'(target_floor), 32'd4);
    check("single_grant",      32'(grant),        32'h8);
    check("single_pending_clr", 32'(pending),     32'h0);
    n = 0;
    while (move_req && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    load_len = 0;
    while (!move_req && (load_len < 100)) begin
      load_len++;
      @(negedge clk);
    end
    check("single_load_len",    32'(load_len),     32'd4);
    check("single_home_target", 32'(target_floor), 32'd0);
    n = 0;
    while (!wash_start && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    pulse_len = 0;
    while (wash_start && (pulse_len < 10)) begin
      pulse_len++;
      @(negedge clk);
    end
    check("single_wash_start_len", 32'(pulse_len), 32'd1);
    check("single_wash_busy",      32'(busy),      32'd1);
    wait_serve("single");
    check("single_serve_grant", 32'(grant), 32'h0);
    @(negedge clk);
    check("single_serve_len",   32'(serve_done), 32'd0);
    // rr wrapped to 0 after floor 4, so floor 1 wins over floor 4.
    pulse_req(4'b1001);
    wait_grant("single_rr");
    check("single_rr_wrap", 32'(grant), 32'h1);

    // Round-robin job table.
    do_reset();
    start = 1'b1;
    foreach (vecs[i]) begin
      req_laundry = vecs[i].req;
      wait_grant($sformatf("rr%0d", i));
      check($sformatf("rr%0d_grant", i),  32'(grant),        32'(vecs[i].exp_grant));
      check($sformatf("rr%0d_target", i), 32'(target_floor), 32'(vecs[i].exp_target));
      check($sformatf("rr%0d_move", i),   32'(move_req),     32'd1);
      wait_serve($sformatf("rr%0d", i));
    end
    req_laundry = 4'b0000;

    // start dropped during WASH: job completes, then no new arbitration.
    do_reset();
    start = 1'b1;
    pulse_req(4'b0010);
    n = 0;
    while (!wash_start && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check("stop_wash_seen", 32'(wash_start), 32'd1);
    start = 1'b0;
    pulse_req(4'b0100);
    wait_serve("stop");
    saw_busy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    check("stop_no_arb",  32'(saw_busy), 32'd0);
    check("stop_pending", 32'(pending),  32'h4);
    check("stop_grant",   32'(grant),    32'h0);
    start = 1'b1;
    wait_grant("stop_resume");
    check("stop_resume_grant",  32'(grant),        32'h4);
    check("stop_resume_target", 32'(target_floor), 32'd3);
    wait_serve("stop_resume");

    // Reset mid-LOAD clears outputs asynchronously and restarts rr at 0.
    do_reset();
    start = 1'b1;
    pulse_req(4'b0001);
    wait_grant("mid_a");
    wait_serve("mid_a");
    pulse_req(4'b0100);
    wait_grant("mid_b");
    check("mid_b_grant", 32'(grant), 32'h4);
    n = 0;
    while (move_req && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    check("mid_in_load", 32'(busy && !move_req), 32'd1);
    #2 reset = 1'b0;
    #1 check_all_zero("mid_async");
    @(negedge clk);
    reset = 1'b1;
    pulse_req(4'b0011);
    wait_grant("mid_restart");
    check("mid_restart_grant", 32'(grant), 32'h1);
    wait_serve("mid_restart");

    // Move timeout: carrier never leaves floor 0.
    do_reset();
    carrier_en = 1'b0;
    start      = 1'b1;
    pulse_req(4'b0001);
    n = 0;
    while (!move_req && (n < 20)) begin
      @(negedge clk);
      n++;
    end
    check("to_move_seen", 32'(move_req), 32'd1);
    n = 0;
    while (!fault && (n < 200)) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles",   32'(n),        32'd64);
    check("to_fault",    32'(fault),    32'd1);
    check("to_move_req", 32'(move_req), 32'd0);
    check("to_busy",     32'(busy),     32'd0);
    check("to_grant",    32'(grant),    32'h0);
    pulse_req(4'b1000);
    repeat (5) @(negedge clk);
    check("to_sticky",   32'(fault),    32'd1);
    check("to_pending",  32'(pending),  32'h8);
    check("to_idle_move", 32'(move_req), 32'd0);
    do_reset();
    check("to_cleared",  32'(fault),    32'd0);
    carrier_en = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
